card_click_locator: RTL and testbench
=====================================

Name: card_click_locator

Overview:
- Downstream consumer of the card position generator. It requests the full position stream, latches every card's {y,x} top-left corner into a local table, then resolves mouse clicks to a card index.
- Hit-testing is a sequential scan of the table, one entry per cycle, using the current card width and height.
- Results go to the game-logic FSM, which handles card reveal and pair matching.

Parameters:
- MAX_CARDS, 16, table depth; largest supported board (hard mode).
- IDX_W, 4, card index width; clog2(MAX_CARDS).
- NUM_W, 5, card count width; matches the card-count field.
- LOAD_DELAY, 2, cycles from the read_all_positions pulse to the first position word on yx_card_position.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_load  in  1  one-cycle pulse: (re)load the table.
- num_of_cards  in  NUM_W  cards on the board (8/12/16); sampled on start_load.
- card_w  in  10  card width in pixels; sampled on click.
- card_h  in  10  card height in pixels; sampled on click.
- read_all_positions  out  1  one-cycle request pulse to the position generator.
- yx_card_position  in  20  [19:10] y, [9:0] x; one word per cycle during load.
- table_ready  out  1  table valid; clicks are accepted.
- click  in  1  one-cycle pulse: mouse left-button press.
- mouse_xpos  in  10  pointer x; sampled on click.
- mouse_ypos  in  10  pointer y; sampled on click.
- pick_valid  out  1  one-cycle pulse: result available.
- pick_hit  out  1  1 = pointer inside a card; held until the next pick_valid.
- pick_idx  out  IDX_W  index of the hit card (0 on miss); held until the next pick_valid.

Behaviour:
- Reset (async assert, sync release): state IDLE, table_ready=0, read_all_positions=0, pick_valid=0, pick_hit=0, pick_idx=0, all table entries={1023,1023}, counters=0.
- States: IDLE, REQ, WAIT, LOAD, READY, SCAN.
- IDLE:
  - start_load at cycle T: latch n=min(num_of_cards, MAX_CARDS), go to REQ.
  - click is ignored.
- REQ:
  - read_all_positions=1 during cycle T+1.
  - Go to WAIT with delay counter = LOAD_DELAY.
- WAIT: count down; at 0 go to LOAD with wr_ptr=0.
- LOAD:
  - Position k is written to entry k at cycle T+1+LOAD_DELAY+k.
  - After entry n-1, go to READY; table_ready rises the next cycle (T+2+LOAD_DELAY+n).
  - Entries >= n are forced to {1023,1023}.
  - n=0: skip LOAD entirely; READY directly after WAIT.
- READY:
  - click at cycle C: latch mouse x/y and card_w/card_h, rd_ptr=0, go to SCAN.
  - table_ready stays 1 during SCAN.
- SCAN, one entry per cycle:
  - Hit when x >= ex && x < ex+card_w && y >= ey && y < ey+card_h.
  - Sums are computed at 11 bits so they cannot wrap.
  - An entry of {1023,1023} never hits.
  - First hit on entry k: pick_valid at cycle C+2+k, pick_hit=1, pick_idx=k, return to READY. The lowest index wins on overlap.
  - No hit: pick_valid at cycle C+1+n, pick_hit=0, pick_idx=0, return to READY.
- Clicks are not queued:
  - A click during SCAN, REQ, WAIT or LOAD is dropped.
  - A click in the same cycle as pick_valid is dropped.
- start_load in any state (including SCAN or LOAD) aborts the current operation:
  - table_ready drops the next cycle.
  - No pick_valid is issued for an aborted scan.
  - The sequence restarts at REQ.
- start_load and click in the same cycle: start_load wins; the click is dropped.
- Reset mid-load or mid-scan: all state is cleared immediately; no partial pick_valid.

Decomposition:
- Shared macro header:
  - MAX_CARDS, card count width, 20-bit YX position width.
  - Sentinel position {1023,1023}.
  - CARD_NUM_EASY/NORMAL/HARD (8/12/16).
  - Per-mode card dimensions.
- One natural sub-module, card_hit_test: combinational rectangle compare taking (x, y, ex, ey, w, h) and returning hit. It is reused by the cursor-hover highlight logic.

Test Plan:
- Load: rst_n low then high; start_load with n=16, stub generator emits {25,50},{25,308}..{550,824} at LOAD_DELAY=2 -> read_all_positions high 1 cycle at T+1, table_ready high at T+20, table contents match.
- Hit: card_w=208, card_h=150, click at x=60,y=30 -> pick_valid at C+2, pick_hit=1, pick_idx=0. Click at x=830,y=560 -> pick_valid at C+17, pick_idx=15.
- Miss and boundary: click at x=258,y=100 (gap) -> pick_valid at C+17, pick_hit=0. Click at x=257,y=25 (last pixel of card 0) -> hit, pick_idx=0.
- Dropped clicks: click before table_ready, and a second click during SCAN -> exactly one pick_valid, for the accepted click only.
- Reload: n=8 with easy positions -> entries 8..15 read {1023,1023}; click at x=60,y=500 -> miss after 9 cycles.
- Abort: start_load mid-scan -> no pick_valid; reload completes. rst_n low mid-LOAD -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/card_click_locator_pkg.sv
// Shared constants and types for the card click locator: table geometry,
// position word layout, board sizes and the locator state encoding.
package card_click_locator_pkg;

    localparam int MAX_CARDS  = 16;
    localparam int IDX_W      = 4;
    localparam int NUM_W      = 5;
    localparam int LOAD_DELAY = 2;
    localparam int COORD_W    = 10;
    localparam int POS_W      = 2 * COORD_W;
    localparam int CNT_W      = $clog2(LOAD_DELAY + 1);

    // {y,x} = {1023,1023}: marks an unused table entry, never hit
    localparam logic [POS_W-1:0] POS_SENTINEL = {POS_W{1'b1}};

    localparam logic [NUM_W-1:0] CARD_NUM_EASY   = 5'd8;
    localparam logic [NUM_W-1:0] CARD_NUM_NORMAL = 5'd12;
    localparam logic [NUM_W-1:0] CARD_NUM_HARD   = 5'd16;

    localparam logic [COORD_W-1:0] CARD_W_EASY   = 10'd208;
    localparam logic [COORD_W-1:0] CARD_H_EASY   = 10'd150;
    localparam logic [COORD_W-1:0] CARD_W_NORMAL = 10'd160;
    localparam logic [COORD_W-1:0] CARD_H_NORMAL = 10'd120;
    localparam logic [COORD_W-1:0] CARD_W_HARD   = 10'd208;
    localparam logic [COORD_W-1:0] CARD_H_HARD   = 10'd150;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_LOAD,
        ST_READY,
        ST_SCAN
    } state_t;

    function automatic logic [NUM_W-1:0] clamp_cards(input logic [NUM_W-1:0] n);
        return (n > NUM_W'(MAX_CARDS)) ? NUM_W'(MAX_CARDS) : n;
    endfunction

endpackage

// File: rtl/card_click_locator_hit_test.sv
// Combinational point-in-rectangle test; also used by the hover highlight.
// Right/bottom edges are formed at 11 bits so cards near 1023 cannot wrap.
module card_hit_test
    import card_click_locator_pkg::*;
(
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [COORD_W-1:0] ex_i,
    input  logic [COORD_W-1:0] ey_i,
    input  logic [COORD_W-1:0] w_i,
    input  logic [COORD_W-1:0] h_i,
    output logic               hit_o
);

    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;

    assign x_end = {1'b0, ex_i} + {1'b0, w_i};
    assign y_end = {1'b0, ey_i} + {1'b0, h_i};

    assign hit_o = (x_i >= ex_i) && ({1'b0, x_i} < x_end) &&
                   (y_i >= ey_i) && ({1'b0, y_i} < y_end);

endmodule

// File: rtl/card_click_locator.sv
// Loads card top-left corners from the position generator into a table,
// then resolves each accepted click to a card index by a one-entry-per-cycle scan.
//
// state | meaning
// IDLE  | no table loaded, clicks ignored
// REQ   | read_all_positions pulse to the generator
// WAIT  | generator latency before the first position word
// LOAD  | one position word written per cycle
// READY | table valid, waiting for a click
// SCAN  | comparing the latched pointer against one entry per cycle
module card_click_locator
    import card_click_locator_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_load_i,
    input  logic [NUM_W-1:0]   num_of_cards_i,
    input  logic [COORD_W-1:0] card_w_i,
    input  logic [COORD_W-1:0] card_h_i,
    output logic               read_all_positions_o,
    input  logic [POS_W-1:0]   yx_card_position_i,
    output logic               table_ready_o,
    input  logic               click_i,
    input  logic [COORD_W-1:0] mouse_xpos_i,
    input  logic [COORD_W-1:0] mouse_ypos_i,
    output logic               pick_valid_o,
    output logic               pick_hit_o,
    output logic [IDX_W-1:0]   pick_idx_o
);

    state_t             state_q, state_d;
    logic [NUM_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [COORD_W-1:0] mx_q, mx_d, my_q, my_d, w_q, w_d, h_q, h_d;
    logic               ready_q, ready_d;
    logic               pv_q, pv_d, hit_q, hit_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [POS_W-1:0]   tbl_q [MAX_CARDS];
    logic               tbl_clr, tbl_we;
    logic [POS_W-1:0]   entry;
    logic               rect_hit, entry_hit;

    assign entry = tbl_q[rd_ptr_q];

    card_hit_test u_hit (
        .x_i   (mx_q),
        .y_i   (my_q),
        .ex_i  (entry[COORD_W-1:0]),
        .ey_i  (entry[POS_W-1:COORD_W]),
        .w_i   (w_q),
        .h_i   (h_q),
        .hit_o (rect_hit)
    );

    assign entry_hit = rect_hit && (entry != POS_SENTINEL);

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mx_d     = mx_q;
        my_d     = my_q;
        w_d      = w_q;
        h_d      = h_q;
        pv_d     = 1'b0;
        hit_d    = hit_q;
        idx_d    = idx_q;
        tbl_clr  = 1'b0;
        tbl_we   = 1'b0;
        ready_d  = ((state_q == ST_READY) || (state_q == ST_SCAN)) && !start_load_i;

        if (start_load_i) begin
            n_d     = clamp_cards(num_of_cards_i);
            tbl_clr = 1'b1;
            state_d = ST_REQ;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                // REQ itself accounts for one cycle of the generator latency
                ST_REQ: begin
                    cnt_d   = CNT_W'(LOAD_DELAY - 1);
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d    = '0;
                        wr_ptr_d = '0;
                        state_d  = (n_q == '0) ? ST_READY : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tbl_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if ({1'b0, wr_ptr_q} == n_q - 1'b1)
                        state_d = ST_READY;
                end
                ST_READY: begin
                    if (click_i && ready_q && !pv_q) begin
                        mx_d     = mouse_xpos_i;
                        my_d     = mouse_ypos_i;
                        w_d      = card_w_i;
                        h_d      = card_h_i;
                        rd_ptr_d = '0;
                        if (n_q == '0) begin
                            pv_d  = 1'b1;
                            hit_d = 1'b0;
                            idx_d = '0;
                        end else begin
                            state_d = ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    if (entry_hit) begin
                        pv_d    = 1'b1;
                        hit_d   = 1'b1;
                        idx_d   = rd_ptr_q;
                        state_d = ST_READY;
                    end else if ({1'b0, rd_ptr_q} == n_q - 1'b1) begin
                        pv_d    = 1'b1;
                        hit_d   = 1'b0;
                        idx_d   = '0;
                        state_d = ST_READY;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            n_q      <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mx_q     <= '0;
            my_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            ready_q  <= 1'b0;
            pv_q     <= 1'b0;
            hit_q    <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mx_q     <= mx_d;
            my_q     <= my_d;
            w_q      <= w_d;
            h_q      <= h_d;
            ready_q  <= ready_d;
            pv_q     <= pv_d;
            hit_q    <= hit_d;
            idx_q    <= idx_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < MAX_CARDS; i++) tbl_q[i] <= POS_SENTINEL;
        end else if (tbl_clr) begin
            for (int i = 0; i < MAX_CARDS; i++) tbl_q[i] <= POS_SENTINEL;
        end else if (tbl_we) begin
            tbl_q[wr_ptr_q] <= yx_card_position_i;
        end
    end

    assign read_all_positions_o = (state_q == ST_REQ);
    assign table_ready_o        = ready_q;
    assign pick_valid_o         = pv_q;
    assign pick_hit_o           = hit_q;
    assign pick_idx_o           = idx_q;

endmodule

// File: tb/tb_card_click_locator.sv
// Directed bench for card_click_locator: stub position generator, a table of
// click vectors on a 16-card board, and hand-written reload/abort/reset sequences.
module tb_card_click_locator;
    import card_click_locator_pkg::*;

    logic               clk_i = 1'b0;
    logic               rst_n_i;
    logic               start_load_i;
    logic [NUM_W-1:0]   num_of_cards_i;
    logic [COORD_W-1:0] card_w_i, card_h_i;
    logic               read_all_positions_o;
    logic [POS_W-1:0]   yx_card_position_i = '0;
    logic               table_ready_o;
    logic               click_i;
    logic [COORD_W-1:0] mouse_xpos_i, mouse_ypos_i;
    logic               pick_valid_o, pick_hit_o;
    logic [IDX_W-1:0]   pick_idx_o;

    card_click_locator dut (
        .clk_i                (clk_i),
        .rst_n_i              (rst_n_i),
        .start_load_i         (start_load_i),
        .num_of_cards_i       (num_of_cards_i),
        .card_w_i             (card_w_i),
        .card_h_i             (card_h_i),
        .read_all_positions_o (read_all_positions_o),
        .yx_card_position_i   (yx_card_position_i),
        .table_ready_o        (table_ready_o),
        .click_i              (click_i),
        .mouse_xpos_i         (mouse_xpos_i),
        .mouse_ypos_i         (mouse_ypos_i),
        .pick_valid_o         (pick_valid_o),
        .pick_hit_o           (pick_hit_o),
        .pick_idx_o           (pick_idx_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    // 4-column grid, 258 px column pitch, 175 px row pitch
    function automatic logic [POS_W-1:0] pos(input int k);
        int y, x;
        y = 25 + 175 * (k / 4);
        x = 50 + 258 * (k % 4);
        return {y[9:0], x[9:0]};
    endfunction

    // Stub generator: words start LOAD_DELAY cycles after the request pulse
    logic [POS_W-1:0] gen_tab [MAX_CARDS];
    int gen_n     = 0;
    int gen_start = -1000;
    always @(negedge clk_i) begin
        if (read_all_positions_o) gen_start = cyc + LOAD_DELAY;
        if (cyc >= gen_start && cyc < gen_start + gen_n)
            yx_card_position_i = gen_tab[cyc - gen_start];
        else
            yx_card_position_i = '0;
    end

    task automatic do_load(input int n, input string tag);
        int t0, lat;
        for (int k = 0; k < MAX_CARDS; k++) gen_tab[k] = pos(k);
        gen_n          = n;
        num_of_cards_i = NUM_W'(n);
        start_load_i   = 1'b1;
        t0             = cyc;
        tick();
        start_load_i = 1'b0;
        chk({tag, "_rap_high"}, int'(read_all_positions_o), 1);
        tick();
        chk({tag, "_rap_low"}, int'(read_all_positions_o), 0);
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            if (table_ready_o) begin
                lat = cyc - t0;
                break;
            end
            tick();
        end
        chk({tag, "_ready_cycle"}, lat, 4 + n);
    endtask

    task automatic do_click(input int x, input int y, input int w, input int h,
                            input string tag, input int e_hit, input int e_idx, input int e_lat);
        int c0, lat, hit, idx;
        mouse_xpos_i = COORD_W'(x);
        mouse_ypos_i = COORD_W'(y);
        card_w_i     = COORD_W'(w);
        card_h_i     = COORD_W'(h);
        click_i      = 1'b1;
        c0           = cyc;
        tick();
        click_i = 1'b0;
        lat = -1; hit = -1; idx = -1;
        for (int i = 0; i < 40; i++) begin
            if (pick_valid_o) begin
                lat = cyc - c0;
                hit = int'(pick_hit_o);
                idx = int'(pick_idx_o);
                break;
            end
            tick();
        end
        chk({tag, "_lat"}, lat, e_lat);
        chk({tag, "_hit"}, hit, e_hit);
        chk({tag, "_idx"}, idx, e_idx);
        tick();
    endtask

    typedef struct {
        int x, y, w, h;
        int hit, idx, lat;
    } vec_t;

    vec_t v [10];

    initial begin
        int c0, ta, lat, idx, npv;

        v[0] = '{60,   30,  208, 150, 1, 0,  2};
        v[1] = '{830,  560, 208, 150, 1, 15, 17};
        v[2] = '{258,  100, 208, 150, 0, 0,  17};
        v[3] = '{257,  25,  208, 150, 1, 0,  2};
        v[4] = '{50,   174, 208, 150, 1, 0,  2};
        v[5] = '{60,   175, 208, 150, 0, 0,  17};
        v[6] = '{49,   30,  208, 150, 0, 0,  17};
        v[7] = '{308,  200, 208, 150, 1, 5,  7};
        v[8] = '{320,  30,  300, 200, 1, 0,  2};
        v[9] = '{1023, 560, 300, 150, 1, 15, 17};

        rst_n_i = 1'b0; start_load_i = 1'b0; click_i = 1'b0;
        num_of_cards_i = '0; card_w_i = '0; card_h_i = '0;
        mouse_xpos_i = '0; mouse_ypos_i = '0;
        repeat (3) tick();
        chk("rst_rap",   int'(read_all_positions_o), 0);
        chk("rst_ready", int'(table_ready_o), 0);
        chk("rst_pv",    int'(pick_valid_o), 0);
        chk("rst_hit",   int'(pick_hit_o), 0);
        chk("rst_idx",   int'(pick_idx_o), 0);
        rst_n_i = 1'b1;
        repeat (2) tick();

        do_load(16, "n16");
        for (int k = 0; k < 16; k++)
            chk($sformatf("n16_tbl%0d", k), int'(dut.tbl_q[k]), int'(pos(k)));

        for (int i = 0; i < 10; i++)
            do_click(v[i].x, v[i].y, v[i].w, v[i].h, $sformatf("vec%0d", i),
                     v[i].hit, v[i].idx, v[i].lat);

        // dropped clicks: during LOAD, during SCAN, and in the pick_valid cycle
        card_w_i = 10'd208; card_h_i = 10'd150;
        start_load_i = 1'b1; ta = cyc;
        tick();
        start_load_i = 1'b0;
        repeat (3) tick();
        mouse_xpos_i = 10'd830; mouse_ypos_i = 10'd560; click_i = 1'b1;
        tick();
        click_i = 1'b0;
        npv = 0; lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (pick_valid_o) npv++;
            if (table_ready_o) begin lat = cyc - ta; break; end
            tick();
        end
        chk("drop_load_ready_cycle", lat, 20);
        chk("drop_load_no_pick", npv, 0);
        mouse_xpos_i = 10'd830; mouse_ypos_i = 10'd560; click_i = 1'b1;
        c0 = cyc;
        tick();
        click_i = 1'b0;
        tick();
        mouse_xpos_i = 10'd60; mouse_ypos_i = 10'd30; click_i = 1'b1;
        tick();
        npv = 0; lat = -1; idx = -1;
        for (int i = 0; i < 40; i++) begin
            click_i = 1'b0;
            if (pick_valid_o) begin
                npv++;
                if (npv == 1) begin
                    lat = cyc - c0;
                    idx = int'(pick_idx_o);
                    mouse_xpos_i = 10'd60; mouse_ypos_i = 10'd30; click_i = 1'b1;
                end
            end
            tick();
        end
        click_i = 1'b0;
        chk("drop_scan_npv", npv, 1);
        chk("drop_scan_lat", lat, 17);
        chk("drop_scan_idx", idx, 15);

        // start_load mid-scan aborts the pick and restarts the load
        mouse_xpos_i = 10'd830; mouse_ypos_i = 10'd560; click_i = 1'b1;
        tick();
        click_i = 1'b0;
        repeat (4) tick();
        num_of_cards_i = 5'd16; start_load_i = 1'b1; ta = cyc;
        tick();
        start_load_i = 1'b0;
        chk("abort_ready_drop", int'(table_ready_o), 0);
        chk("abort_rap", int'(read_all_positions_o), 1);
        npv = 0; lat = -1;
        for (int i = 0; i < 30; i++) begin
            if (pick_valid_o) npv++;
            if (table_ready_o && lat < 0) lat = cyc - ta;
            tick();
        end
        chk("abort_no_pick", npv, 0);
        chk("abort_ready_cycle", lat, 20);
        do_click(60, 30, 208, 150, "abort_after", 1, 0, 2);

        // reload with an easy board
        do_load(8, "n8");
        for (int k = 0; k < 16; k++)
            chk($sformatf("n8_tbl%0d", k), int'(dut.tbl_q[k]),
                (k < 8) ? int'(pos(k)) : int'(POS_SENTINEL));
        do_click(60,  500, 208, 150, "n8_miss", 0, 0, 9);
        do_click(830, 210, 208, 150, "n8_last", 1, 7, 9);

        // asynchronous reset mid-scan
        mouse_xpos_i = 10'd830; mouse_ypos_i = 10'd210; click_i = 1'b1;
        tick();
        click_i = 1'b0;
        repeat (3) tick();
        #2 rst_n_i = 1'b0;
        #1;
        chk("rst_scan_hit",   int'(pick_hit_o), 0);
        chk("rst_scan_idx",   int'(pick_idx_o), 0);
        chk("rst_scan_ready", int'(table_ready_o), 0);
        chk("rst_scan_pv",    int'(pick_valid_o), 0);
        tick();
        rst_n_i = 1'b1;
        npv = 0;
        for (int i = 0; i < 20; i++) begin
            if (pick_valid_o) npv++;
            tick();
        end
        chk("rst_scan_no_pick", npv, 0);
        chk("rst_scan_ready_after", int'(table_ready_o), 0);

        // asynchronous reset mid-load
        num_of_cards_i = 5'd16; start_load_i = 1'b1;
        tick();
        start_load_i = 1'b0;
        repeat (5) tick();
        #2 rst_n_i = 1'b0;
        #1;
        chk("rst_load_tbl0", int'(dut.tbl_q[0]), int'(POS_SENTINEL));
        chk("rst_load_rap",  int'(read_all_positions_o), 0);
        chk("rst_load_ready", int'(table_ready_o), 0);
        tick();
        rst_n_i = 1'b1;
        repeat (25) tick();

        do_load(16, "final");
        do_click(830, 560, 208, 150, "final", 1, 15, 17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
